seq_run_logger: RTL and testbench

//  Downstream consumer of the sequence-detector output (Mealy "11" detector).

---
 rtl/seq_run_logger.sv | 118 +++++++++++
 tb/tb_seq_run_logger.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_run_logger.sv
// Groups consecutive detector hits into runs and queues {start, length} records
// in a small show-ahead FIFO drained over valid/ready, with a saturating run total.
module seq_run_logger #(
  parameter int TW    = 16,
  parameter int LW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          det,
  input  logic          clr,
  input  logic          evt_ready,
  output logic          evt_valid,
  output logic [TW-1:0] evt_start,
  output logic [LW-1:0] evt_len,
  output logic [CW-1:0] evt_total,
  output logic          ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TW + LW;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          st;
  logic [TW-1:0]   time_cnt;
  logic [TW-1:0]   start_r;
  logic [LW-1:0]   len_r;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;

  logic            push;
  logic            pop;
  logic            full;
  logic            accept;
  logic            drop;
  logic [AW:0]     left;
  logic [AW:0]     cnt_nxt;
  logic [AW-1:0]   rd_nxt;
  logic [EW-1:0]   entry;
  logic [EW-1:0]   head_nxt;

  function automatic logic [LW-1:0] sat_len_inc(input logic [LW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CW-1:0] sat_total_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A run completes when RUN samples det=0; clr suppresses it entirely.
  assign push   = (st == RUN) && !det && !clr;
  assign pop    = evt_valid && evt_ready;
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign left   = cnt - (AW+1)'(pop);
  assign cnt_nxt = left + (AW+1)'(accept);
  assign rd_nxt = rd_ptr + AW'(pop);
  assign entry  = {start_r, len_r};
  // When nothing survives the pop, the incoming record becomes the head directly.
  assign head_nxt = (left == '0) ? entry : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (st == IDLE && det) begin
      start_r <= time_cnt;
      len_r   <= LW'(1);
    end else if (st == RUN && det) begin
      len_r <= sat_len_inc(len_r);
    end
    if (accept) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_cnt  <= '0;
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      evt_valid <= 1'b0;
      evt_start <= '0;
      evt_len   <= '0;
      evt_total <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      time_cnt  <= '0;
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      evt_valid <= 1'b0;
      evt_start <= '0;
      evt_len   <= '0;
      evt_total <= '0;
      ovf       <= 1'b0;
    end else begin
      time_cnt <= time_cnt + 1'b1;
      case (st)
        IDLE:    if (det) st <= RUN;
        RUN:     if (!det) st <= IDLE;
        default: st <= IDLE;
      endcase
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_nxt;
      cnt       <= cnt_nxt;
      evt_valid <= (cnt_nxt != '0);
      // Head registers hold their last value while the FIFO is empty.
      if (cnt_nxt != '0) {evt_start, evt_len} <= head_nxt;
      if (push) evt_total <= sat_total_inc(evt_total);
      if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_run_logger.sv
// Directed bench for seq_run_logger; a second instance with TW=4 covers timestamp wrap.
module tb_seq_run_logger;

  logic        clk = 1'b0;
  logic        reset;
  logic        det;
  logic        clr;
  logic        evt_ready;
  logic        evt_valid;
  logic [15:0] evt_start;
  logic [7:0]  evt_len;
  logic [15:0] evt_total;
  logic        ovf;
  logic        w_valid;
  logic [3:0]  w_start;
  logic [7:0]  w_len;
  logic [15:0] w_total;
  logic        w_ovf;

  int checks = 0;
  int failures = 0;

  seq_run_logger #(.TW(16), .LW(8), .DEPTH(4), .CW(16)) u_dut (
    .clk(clk), .reset(reset), .det(det), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_start(evt_start), .evt_len(evt_len),
    .evt_total(evt_total), .ovf(ovf)
  );

  seq_run_logger #(.TW(4), .LW(8), .DEPTH(4), .CW(16)) u_wrap (
    .clk(clk), .reset(reset), .det(det), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(w_valid), .evt_start(w_start), .evt_len(w_len),
    .evt_total(w_total), .ovf(w_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic d, input logic r);
    det = d;
    evt_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_starts [3] = '{19, 21, 23};
    reset = 1'b1;
    det = 1'b0;
    clr = 1'b0;
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_start", evt_start, 0);
    check("rst_len", evt_len, 0);
    check("rst_total", evt_total, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;

    // single run on edges 5..7, pushed at edge 8
    repeat (5) step(0, 0);
    repeat (3) step(1, 0);
    step(0, 0);
    check("t1_valid", evt_valid, 1);
    check("t1_start", evt_start, 5);
    check("t1_len", evt_len, 3);
    check("t1_total", evt_total, 1);
    step(0, 1);
    check("t1_popped", evt_valid, 0);
    check("t1_hold_start", evt_start, 5);
    check("t1_hold_len", evt_len, 3);

    // 1,0,1,0 from edge 10 with ready high
    step(1, 1);
    step(0, 1);
    check("t2_valid_a", evt_valid, 1);
    check("t2_start_a", evt_start, 10);
    check("t2_len_a", evt_len, 1);
    step(1, 1);
    check("t2_empty_a", evt_valid, 0);
    step(0, 1);
    check("t2_valid_b", evt_valid, 1);
    check("t2_start_b", evt_start, 12);
    step(0, 1);
    check("t2_empty_b", evt_valid, 0);
    check("t2_total", evt_total, 3);

    // fill FIFO with runs at 15,17,19,21
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      step(0, 0);
    end
    check("fill_valid", evt_valid, 1);
    check("fill_start", evt_start, 15);
    check("fill_ovf", ovf, 0);
    check("fill_total", evt_total, 7);

    // full, run completes with ready high: push and pop together
    step(1, 0);
    step(0, 1);
    check("t4_start", evt_start, 17);
    check("t4_ovf", ovf, 0);
    check("t4_total", evt_total, 8);

    // full, no pop: run at 25 is dropped
    step(1, 0);
    step(0, 0);
    check("t3_ovf", ovf, 1);
    check("t3_total", evt_total, 9);
    check("t3_head", evt_start, 17);
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      check("t3_drain", evt_start, exp_starts[i]);
    end
    step(0, 1);
    check("t3_drained", evt_valid, 0);

    // 300-cycle run from edge 31; wrap instance sees start 31 mod 16 = 15
    repeat (300) step(1, 0);
    step(0, 0);
    check("t5_valid", evt_valid, 1);
    check("t5_start", evt_start, 31);
    check("t5_len", evt_len, 255);
    check("t5_total", evt_total, 10);
    check("t5_wrap_start", w_start, 15);
    check("t5_wrap_len", w_len, 255);
    step(0, 1);
    check("t5_popped", evt_valid, 0);

    // two entries queued, run in progress, then clr
    step(1, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    check("t6_queued", evt_start, 333);
    step(1, 0);
    clr = 1'b1;
    step(1, 0);
    clr = 1'b0;
    check("t6_clr_valid", evt_valid, 0);
    check("t6_clr_total", evt_total, 0);
    check("t6_clr_ovf", ovf, 0);
    check("t6_clr_start", evt_start, 0);
    check("t6_clr_len", evt_len, 0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    check("t6_restart_start", evt_start, 0);
    check("t6_restart_len", evt_len, 2);
    check("t6_restart_total", evt_total, 1);

    // async reset mid-run, checked between clock edges
    step(1, 0);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", evt_valid, 0);
    check("ar_total", evt_total, 0);
    check("ar_start", evt_start, 0);
    check("ar_len", evt_len, 0);
    check("ar_wrap_valid", w_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0);
    step(0, 0);
    check("ar_after_start", evt_start, 0);
    check("ar_after_len", evt_len, 1);
    check("ar_after_total", evt_total, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
